// File: rtl/illusion_fb_pkg.sv
// Shared framebuffer definitions: geometry, pixel type, writer states and
// the filled-rectangle command record.
package illusion_fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    // 17 bits cover every buffer-relative address of a 320x240 frame.
    localparam int ADDR_BITS = 17;

    typedef logic [2:0] pixel_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] x1;
        logic [7:0] y0;
        logic [7:0] y1;
        pixel_t     color;
        logic       last;
    } rect_cmd_t;

    // Start-of-rect row base y*width built from shifted adds of the
    // constant width, so no general multiplier is needed.
    function automatic logic [ADDR_BITS-1:0] rowOffset(input logic [7:0] y, input int width);
        logic [ADDR_BITS-1:0] acc;
        logic [ADDR_BITS-1:0] w;
        acc = {ADDR_BITS{1'b0}};
        w   = ADDR_BITS'(width);
        for (int i = 0; i < 8; i++) begin
            acc = acc + (y[i] ? (w << i) : {ADDR_BITS{1'b0}});
        end
        return acc;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster walker for one rectangle: x inner, y outer. Keeps the current
// pixel position, an incrementally updated row base and a flag that marks
// the current pixel as the last one of the rectangle.
module rect_scanner
    import illusion_fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT
) (
    input  logic                 aClock,
    input  logic                 aReset,
    input  logic                 aLoad,
    input  logic [8:0]           aLoadX0,
    input  logic [8:0]           aLoadX1,
    input  logic [7:0]           aLoadY0,
    input  logic [7:0]           aLoadY1,
    input  logic                 aStep,
    output logic [ADDR_BITS-1:0] aLoadAddr,
    output logic [ADDR_BITS-1:0] aStepAddr,
    output logic                 aLastPixel
);

    localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(WIDTH);
    localparam logic [8:0]           X_MAX    = 9'(WIDTH - 1);
    localparam logic [7:0]           Y_MAX    = 8'(HEIGHT - 1);

    logic [8:0]           x_r;
    logic [7:0]           y_r;
    logic [ADDR_BITS-1:0] rowBase_r;
    logic [8:0]           x0_r;
    logic [8:0]           x1_r;
    logic [7:0]           y1_r;
    logic                 lastPixel_r;

    logic                 wrap_s;
    logic [8:0]           nextX_s;
    logic [7:0]           nextY_s;
    logic [ADDR_BITS-1:0] nextRowBase_s;
    logic [ADDR_BITS-1:0] loadRowBase_s;

    // Address of the first pixel of a newly loaded rect and of the pixel after the current one
    always_comb begin
        loadRowBase_s = rowOffset(aLoadY0, WIDTH);
        aLoadAddr     = loadRowBase_s + {8'd0, aLoadX0};
        wrap_s        = (x_r == x1_r);
        if (wrap_s) begin
            nextX_s       = x0_r;
            nextY_s       = y_r + 8'd1;
            nextRowBase_s = rowBase_r + ROW_STEP;
        end else begin
            nextX_s       = x_r + 9'd1;
            nextY_s       = y_r;
            nextRowBase_s = rowBase_r;
        end
        aStepAddr = nextRowBase_s + {8'd0, nextX_s};
    end

    // Position, bounds and last-pixel tracking; reset parks on a full-frame rect at (0,0)
    always_ff @(posedge aClock) begin
        if (aReset) begin
            x_r         <= 9'd0;
            y_r         <= 8'd0;
            rowBase_r   <= {ADDR_BITS{1'b0}};
            x0_r        <= 9'd0;
            x1_r        <= X_MAX;
            y1_r        <= Y_MAX;
            lastPixel_r <= 1'b0;
        end else if (aLoad) begin
            x_r         <= aLoadX0;
            y_r         <= aLoadY0;
            rowBase_r   <= loadRowBase_s;
            x0_r        <= aLoadX0;
            x1_r        <= aLoadX1;
            y1_r        <= aLoadY1;
            lastPixel_r <= (aLoadX0 == aLoadX1) && (aLoadY0 == aLoadY1);
        end else if (aStep) begin
            x_r         <= nextX_s;
            y_r         <= nextY_s;
            rowBase_r   <= nextRowBase_s;
            lastPixel_r <= (nextX_s == x1_r) && (nextY_s == y1_r);
        end else begin
            x_r         <= x_r;
            y_r         <= y_r;
            rowBase_r   <= rowBase_r;
            lastPixel_r <= lastPixel_r;
        end
    end

    assign aLastPixel = lastPixel_r;

endmodule

// File: rtl/rect_fill_writer.sv
// Frame writer: clears the back buffer, fills rectangles from a command
// stream one pixel per cycle, then raises frame-done until the display
// side flips the buffers.
module rect_fill_writer
    import illusion_fb_pkg::*;
#(
    parameter int     WIDTH       = FB_WIDTH,
    parameter int     HEIGHT      = FB_HEIGHT,
    parameter pixel_t CLEAR_COLOR = 3'd0
) (
    input  logic        aClock,
    input  logic        aReset,
    input  logic        aCmdValid,
    output logic        anOutCmdReady,
    input  logic [8:0]  aCmdX0,
    input  logic [8:0]  aCmdX1,
    input  logic [7:0]  aCmdY0,
    input  logic [7:0]  aCmdY1,
    input  logic [2:0]  aCmdColor,
    input  logic        aCmdLast,
    input  logic        aFrameFlipped,
    output logic        anOutFrameDone,
    output logic [31:0] anOutPixelAddr,
    output logic [2:0]  anOutPixelData,
    output logic        anOutPixelWrite
);

    localparam logic [8:0] X_MAX = 9'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    writer_state_t        state_r;
    logic                 clearFirst_r;
    pixel_t               cmdColor_r;
    logic                 cmdLast_r;

    rect_cmd_t            cmdIn_s;
    logic                 cmdEmpty_s;
    logic                 accept_s;

    logic                 scanLoad_s;
    logic                 scanStep_s;
    logic [8:0]           loadX0_s;
    logic [8:0]           loadX1_s;
    logic [7:0]           loadY0_s;
    logic [7:0]           loadY1_s;
    logic [ADDR_BITS-1:0] loadAddr_s;
    logic [ADDR_BITS-1:0] stepAddr_s;
    logic                 lastPixel_s;

    // Incoming command with the far corner clamped to the frame; a start at or past the edge reads as empty
    always_comb begin
        cmdIn_s.x0    = aCmdX0;
        cmdIn_s.x1    = (aCmdX1 > X_MAX) ? X_MAX : aCmdX1;
        cmdIn_s.y0    = aCmdY0;
        cmdIn_s.y1    = (aCmdY1 > Y_MAX) ? Y_MAX : aCmdY1;
        cmdIn_s.color = aCmdColor;
        cmdIn_s.last  = aCmdLast;
        cmdEmpty_s    = (cmdIn_s.x0 > cmdIn_s.x1) || (cmdIn_s.y0 > cmdIn_s.y1);
        accept_s      = aCmdValid && anOutCmdReady;
    end

    // Scanner control: load a command rect on accept, a full-frame rect on flip, step while sweeping
    always_comb begin
        scanLoad_s = 1'b0;
        scanStep_s = 1'b0;
        loadX0_s   = 9'd0;
        loadX1_s   = X_MAX;
        loadY0_s   = 8'd0;
        loadY1_s   = Y_MAX;
        case (state_r)
            CLEAR: begin
                scanStep_s = !clearFirst_r && !lastPixel_s;
            end
            IDLE: begin
                if (accept_s && !cmdEmpty_s) begin
                    scanLoad_s = 1'b1;
                    loadX0_s   = cmdIn_s.x0;
                    loadX1_s   = cmdIn_s.x1;
                    loadY0_s   = cmdIn_s.y0;
                    loadY1_s   = cmdIn_s.y1;
                end else begin
                    scanLoad_s = 1'b0;
                end
            end
            FILL: begin
                scanStep_s = !lastPixel_s;
            end
            DONE: begin
                scanLoad_s = aFrameFlipped;
            end
            default: begin
                scanLoad_s = 1'b0;
                scanStep_s = 1'b0;
            end
        endcase
    end

    rect_scanner #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) uScanner (
        .aClock     (aClock),
        .aReset     (aReset),
        .aLoad      (scanLoad_s),
        .aLoadX0    (loadX0_s),
        .aLoadX1    (loadX1_s),
        .aLoadY0    (loadY0_s),
        .aLoadY1    (loadY1_s),
        .aStep      (scanStep_s),
        .aLoadAddr  (loadAddr_s),
        .aStepAddr  (stepAddr_s),
        .aLastPixel (lastPixel_s)
    );

    // Frame state machine with registered handshake and pixel outputs
    always_ff @(posedge aClock) begin
        if (aReset) begin
            state_r         <= CLEAR;
            clearFirst_r    <= 1'b1;
            cmdColor_r      <= CLEAR_COLOR;
            cmdLast_r       <= 1'b0;
            anOutCmdReady   <= 1'b0;
            anOutFrameDone  <= 1'b0;
            anOutPixelWrite <= 1'b0;
            anOutPixelAddr  <= 32'd0;
            anOutPixelData  <= 3'd0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clearFirst_r) begin
                        // After reset the scanner already sits on pixel 0.
                        clearFirst_r    <= 1'b0;
                        anOutPixelWrite <= 1'b1;
                        anOutPixelAddr  <= 32'd0;
                        anOutPixelData  <= CLEAR_COLOR;
                    end else if (lastPixel_s) begin
                        anOutPixelWrite <= 1'b0;
                        anOutCmdReady   <= 1'b1;
                        state_r         <= IDLE;
                    end else begin
                        anOutPixelWrite <= 1'b1;
                        anOutPixelAddr  <= {15'd0, stepAddr_s};
                        anOutPixelData  <= CLEAR_COLOR;
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        cmdColor_r <= cmdIn_s.color;
                        cmdLast_r  <= cmdIn_s.last;
                        if (cmdEmpty_s) begin
                            anOutPixelWrite <= 1'b0;
                            if (cmdIn_s.last) begin
                                anOutCmdReady  <= 1'b0;
                                anOutFrameDone <= 1'b1;
                                state_r        <= DONE;
                            end else begin
                                anOutCmdReady  <= 1'b1;
                                state_r        <= IDLE;
                            end
                        end else begin
                            anOutCmdReady   <= 1'b0;
                            anOutPixelWrite <= 1'b1;
                            anOutPixelAddr  <= {15'd0, loadAddr_s};
                            anOutPixelData  <= cmdIn_s.color;
                            state_r         <= FILL;
                        end
                    end else begin
                        anOutPixelWrite <= 1'b0;
                    end
                end
                FILL: begin
                    if (lastPixel_s) begin
                        anOutPixelWrite <= 1'b0;
                        if (cmdLast_r) begin
                            anOutFrameDone <= 1'b1;
                            state_r        <= DONE;
                        end else begin
                            anOutCmdReady  <= 1'b1;
                            state_r        <= IDLE;
                        end
                    end else begin
                        anOutPixelWrite <= 1'b1;
                        anOutPixelAddr  <= {15'd0, stepAddr_s};
                        anOutPixelData  <= cmdColor_r;
                    end
                end
                DONE: begin
                    if (aFrameFlipped) begin
                        // Scanner reloads a full-frame rect this edge; pixel 0 goes out now.
                        anOutFrameDone  <= 1'b0;
                        anOutPixelWrite <= 1'b1;
                        anOutPixelAddr  <= 32'd0;
                        anOutPixelData  <= CLEAR_COLOR;
                        state_r         <= CLEAR;
                    end else begin
                        anOutPixelWrite <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= CLEAR;
                    clearFirst_r    <= 1'b1;
                    anOutCmdReady   <= 1'b0;
                    anOutFrameDone  <= 1'b0;
                    anOutPixelWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed and randomized bench for rect_fill_writer. Uses a full-width,
// short frame so every clear stays cheap while row-base arithmetic keeps
// the real 320-pixel pitch.
module tb_rect_fill_writer;

    localparam int W = 320;
    localparam int H = 12;
    localparam int N = W * H;

    logic        aClock = 1'b0;
    logic        aReset;
    logic        aCmdValid;
    logic        anOutCmdReady;
    logic [8:0]  aCmdX0;
    logic [8:0]  aCmdX1;
    logic [7:0]  aCmdY0;
    logic [7:0]  aCmdY1;
    logic [2:0]  aCmdColor;
    logic        aCmdLast;
    logic        aFrameFlipped;
    logic        anOutFrameDone;
    logic [31:0] anOutPixelAddr;
    logic [2:0]  anOutPixelData;
    logic        anOutPixelWrite;

    rect_fill_writer #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .CLEAR_COLOR (3'd0)
    ) dut (
        .aClock          (aClock),
        .aReset          (aReset),
        .aCmdValid       (aCmdValid),
        .anOutCmdReady   (anOutCmdReady),
        .aCmdX0          (aCmdX0),
        .aCmdX1          (aCmdX1),
        .aCmdY0          (aCmdY0),
        .aCmdY1          (aCmdY1),
        .aCmdColor       (aCmdColor),
        .aCmdLast        (aCmdLast),
        .aFrameFlipped   (aFrameFlipped),
        .anOutFrameDone  (anOutFrameDone),
        .anOutPixelAddr  (anOutPixelAddr),
        .anOutPixelData  (anOutPixelData),
        .anOutPixelWrite (anOutPixelWrite)
    );

    always #5 aClock = ~aClock;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [2:0] dutFb   [N];
    logic [2:0] modelFb [N];
    int writeCount = 0;
    int areaSum    = 0;

    int cX0 [32];
    int cX1 [32];
    int cY0 [32];
    int cY1 [32];
    int cC  [32];
    int gap [32];
    int nCmd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1ns later and enabled writes land in dutFb.
    task automatic tick;
        @(posedge aClock);
        #1;
        if (anOutPixelWrite && !anOutFrameDone) begin
            if (anOutPixelAddr < N) dutFb[anOutPixelAddr] = anOutPixelData;
            writeCount++;
        end
    endtask

    task automatic drivePayload(input int i);
        aCmdX0    = 9'(cX0[i]);
        aCmdX1    = 9'(cX1[i]);
        aCmdY0    = 8'(cY0[i]);
        aCmdY1    = 8'(cY1[i]);
        aCmdColor = 3'(cC[i]);
        aCmdLast  = (i == nCmd - 1);
        aCmdValid = 1'b1;
    endtask

    // Full clear sweep; when first is set the pixel-0 cycle is already on the outputs.
    task automatic doClear(input bit first);
        int bad;
        for (int a = 0; a < N; a++) begin
            if (!(first && a == 0)) tick;
            check("clearWrite", anOutPixelWrite, 1);
            check("clearAddr", anOutPixelAddr, a);
            check("clearData", anOutPixelData, 0);
            check("clearReady", anOutCmdReady, 0);
        end
        tick;
        check("clearEndReady", anOutCmdReady, 1);
        check("clearEndWrite", anOutPixelWrite, 0);
        check("clearEndDone", anOutFrameDone, 0);
        bad = 0;
        for (int p = 0; p < N; p++) begin
            modelFb[p] = 3'd0;
            if (dutFb[p] !== 3'd0) bad++;
        end
        check("clearFb", bad, 0);
        writeCount = 0;
        areaSum    = 0;
    endtask

    // Present command i (after its gap unless already chained), follow its writes pixel by pixel.
    task automatic execCmd(input int i, input int flipAt);
        int x1c, y1c, pix;
        bit last, empty;
        if (!aCmdValid) begin
            for (int g = 0; g < gap[i]; g++) begin
                tick;
                check("gapReady", anOutCmdReady, 1);
                check("gapNoWrite", anOutPixelWrite, 0);
            end
            drivePayload(i);
        end
        for (int k = 0; k < 64 && !anOutCmdReady; k++) tick;
        check("readyBeforeAccept", anOutCmdReady, 1);
        tick;
        last = (i == nCmd - 1);
        if (i + 1 < nCmd && gap[i + 1] == 0) drivePayload(i + 1);
        else aCmdValid = 1'b0;
        x1c   = (cX1[i] > W - 1) ? W - 1 : cX1[i];
        y1c   = (cY1[i] > H - 1) ? H - 1 : cY1[i];
        empty = (cX0[i] > x1c) || (cY0[i] > y1c);
        if (empty) begin
            check("emptyNoWrite", anOutPixelWrite, 0);
            check("emptyReady", anOutCmdReady, !last);
            check("emptyDone", anOutFrameDone, last);
        end else begin
            pix = 0;
            for (int y = cY0[i]; y <= y1c; y++) begin
                for (int x = cX0[i]; x <= x1c; x++) begin
                    if (pix > 0) tick;
                    aFrameFlipped = (pix == flipAt);
                    check("fillWrite", anOutPixelWrite, 1);
                    check("fillAddr", anOutPixelAddr, y * W + x);
                    check("fillData", anOutPixelData, cC[i]);
                    check("fillReady", anOutCmdReady, 0);
                    check("fillDone", anOutFrameDone, 0);
                    modelFb[y * W + x] = 3'(cC[i]);
                    areaSum++;
                    pix++;
                end
            end
            tick;
            aFrameFlipped = 1'b0;
            check("endNoWrite", anOutPixelWrite, 0);
            check("endReady", anOutCmdReady, !last);
            check("endDone", anOutFrameDone, last);
        end
    endtask

    task automatic compareFrame;
        int bad;
        bad = 0;
        for (int p = 0; p < N; p++) begin
            if (dutFb[p] !== modelFb[p]) bad++;
        end
        check("frameMatch", bad, 0);
        check("pixelCount", writeCount, areaSum);
    endtask

    task automatic holdAndFlip(input int holdCycles);
        for (int c = 0; c < holdCycles; c++) begin
            tick;
            check("holdDone", anOutFrameDone, 1);
            check("holdNoWrite", anOutPixelWrite, 0);
            check("holdReady", anOutCmdReady, 0);
        end
        aFrameFlipped = 1'b1;
        tick;
        aFrameFlipped = 1'b0;
        check("flipDone", anOutFrameDone, 0);
        check("flipWrite", anOutPixelWrite, 1);
        check("flipAddr", anOutPixelAddr, 0);
        doClear(1'b1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aReset        = 1'b1;
        aCmdValid     = 1'b0;
        aCmdX0        = 9'd0;
        aCmdX1        = 9'd0;
        aCmdY0        = 8'd0;
        aCmdY1        = 8'd0;
        aCmdColor     = 3'd0;
        aCmdLast      = 1'b0;
        aFrameFlipped = 1'b0;
        for (int p = 0; p < N; p++) begin
            dutFb[p]   = 3'd7;
            modelFb[p] = 3'd0;
        end

        // Reset values
        repeat (3) tick;
        check("rstReady", anOutCmdReady, 0);
        check("rstDone", anOutFrameDone, 0);
        check("rstWrite", anOutPixelWrite, 0);
        check("rstAddr", anOutPixelAddr, 0);
        check("rstData", anOutPixelData, 0);

        // Power-on clear
        aReset = 1'b0;
        doClear(1'b0);

        // Frame 1: directed rects, flip injected during the first fill
        nCmd = 4;
        cX0[0] = 10;  cX1[0] = 12;  cY0[0] = 5;  cY1[0] = 6;   cC[0] = 5; gap[0] = 1;
        cX0[1] = 318; cX1[1] = 400; cY0[1] = 11; cY1[1] = 255; cC[1] = 3; gap[1] = 0;
        cX0[2] = 5;   cX1[2] = 4;   cY0[2] = 5;  cY1[2] = 9;   cC[2] = 2; gap[2] = 2;
        cX0[3] = 0;   cX1[3] = 0;   cY0[3] = 0;  cY1[3] = 0;   cC[3] = 6; gap[3] = 0;
        execCmd(0, 2);
        execCmd(1, -1);
        execCmd(2, -1);
        execCmd(3, -1);
        compareFrame();
        holdAndFlip(100);

        // Frame 2: random rects, random gaps, overlaps and clamping
        nCmd = 12;
        for (int i = 0; i < nCmd; i++) begin
            cX0[i] = int'($urandom_range(0, 330));
            cX1[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 340))
                                                 : cX0[i] + int'($urandom_range(0, 40));
            cY0[i] = int'($urandom_range(0, 13));
            cY1[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20))
                                                 : cY0[i] + int'($urandom_range(0, 3));
            cC[i]  = int'($urandom_range(0, 7));
            gap[i] = int'($urandom_range(0, 3));
        end
        for (int i = 0; i < nCmd; i++) execCmd(i, -1);
        compareFrame();
        holdAndFlip(5);

        // Frame 3: reset in the middle of a large fill
        nCmd = 1;
        cX0[0] = 0; cX1[0] = 319; cY0[0] = 0; cY1[0] = 11; cC[0] = 4; gap[0] = 0;
        drivePayload(0);
        for (int k = 0; k < 64 && !anOutCmdReady; k++) tick;
        check("bigReady", anOutCmdReady, 1);
        tick;
        aCmdValid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) tick;
            check("bigWrite", anOutPixelWrite, 1);
            check("bigAddr", anOutPixelAddr, k);
        end
        aReset = 1'b1;
        tick;
        check("midRstReady", anOutCmdReady, 0);
        check("midRstDone", anOutFrameDone, 0);
        check("midRstWrite", anOutPixelWrite, 0);
        check("midRstAddr", anOutPixelAddr, 0);
        check("midRstData", anOutPixelData, 0);
        aReset = 1'b0;
        doClear(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
